// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared size encodings, FSM state type and write-mask helpers for
//          the load/store front-end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Expands a byte-lane mask into a per-bit mask.
  function automatic logic [63:0] mask_to_bits(input logic [7:0] mask);
    logic [63:0] bits;
    for (int i = 0; i < 8; i++) begin
      bits[i*8 +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align_ext.sv
// ============================================================================
// Module : load_align_ext
// Brief  : Extracts the low 1/2/4/8 bytes of memory read data and zero- or
//          sign-extends them to 64 bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_align_ext
  import mem_pkg::*;
(
  input  logic [63:0] rd_data,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [63:0] ext_data
);

  always_comb begin
    ext_data = rd_data;
    case (size)
      SZ_B:    ext_data = {{56{is_signed & rd_data[7]}},  rd_data[7:0]};
      SZ_H:    ext_data = {{48{is_signed & rd_data[15]}}, rd_data[15:0]};
      SZ_W:    ext_data = {{32{is_signed & rd_data[31]}}, rd_data[31:0]};
      default: ext_data = rd_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : Single-outstanding load/store front-end with alignment and range
//          checking, one-cycle memory access and a held, registered response.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter logic [63:0] PMEM_BASE = 64'h8000_0000,
  parameter logic [63:0] PMEM_SIZE = 64'h0800_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        rd_en,
  output logic [63:0] rd_addr,
  input  logic [63:0] rd_data,
  output logic        we_en,
  output logic [63:0] we_addr,
  output logic [63:0] we_data,
  output logic [7:0]  we_mask
);

  localparam logic [64:0] c_pmem_limit = {1'b0, PMEM_BASE} + {1'b0, PMEM_SIZE};

  state_t      r_state;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_we_en;

  logic [64:0] w_bytes;
  logic [64:0] w_end;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_err;
  logic [7:0]  w_mask;
  logic [63:0] w_ext;

  // 65-bit end address so a request near the top of the address space
  // cannot wrap around into the legal window.
  always_comb begin
    w_bytes = 65'd1 << req_size;
    w_end   = {1'b0, req_addr} + w_bytes;
    case (req_size)
      SZ_B:    w_misaligned = 1'b0;
      SZ_H:    w_misaligned = req_addr[0];
      SZ_W:    w_misaligned = |req_addr[1:0];
      default: w_misaligned = |req_addr[2:0];
    endcase
    w_out_of_range = (req_addr < PMEM_BASE) || (w_end > c_pmem_limit);
    w_err          = w_misaligned | w_out_of_range;
    w_mask         = size_to_mask(req_size);
  end

  load_align_ext u_load_align_ext (
    .rd_data   (rd_data),
    .size      (r_size),
    .is_signed (r_signed),
    .ext_data  (w_ext)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_size     <= SZ_B;
      r_signed   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= 64'd0;
      r_we_en    <= 1'b0;
      we_addr    <= 64'd0;
      we_data    <= 64'd0;
      we_mask    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_size    <= req_size;
            r_signed  <= req_signed;
            if (w_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 64'd0;
              r_state    <= ST_RESP;
            end else if (req_wen) begin
              r_we_en <= 1'b1;
              we_addr <= req_addr;
              we_data <= req_wdata & mask_to_bits(w_mask);
              we_mask <= w_mask;
              r_state <= ST_WR;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= req_addr;
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          rd_en      <= 1'b0;
          rd_addr    <= 64'd0;
          resp_rdata <= w_ext;
          resp_valid <= 1'b1;
          r_state    <= ST_RESP;
        end
        ST_WR: begin
          r_we_en    <= 1'b0;
          we_addr    <= 64'd0;
          we_data    <= 64'd0;
          we_mask    <= 8'd0;
          resp_rdata <= 64'd0;
          resp_valid <= 1'b1;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
            req_ready  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A reset arriving during the write cycle must suppress the strobe the
  // memory would otherwise capture at the closing edge.
  assign we_en = r_we_en & ~reset;

endmodule

`default_nettype wire
